led_scan6: RTL



---
 rtl/led_scan6.sv | 110 +++++++++++
 1 files changed

// File: rtl/led_scan6.sv
// Six-digit multiplexed seven-segment scanner for the digital clock.
// Inputs are snapshotted once per frame so a frame never shows a mid-carry time.
module led_scan6 #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit LZB          = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [1:0] blink_sel,
    output logic [7:0] seg,
    output logic [5:0] dig
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [FW-1:0] fcnt;
    logic          ph;
    logic [7:0]    snap_hour, snap_min, snap_sec;
    logic [1:0]    snap_blink_sel;

    logic          tick, wrap;
    logic [3:0]    nib;
    logic [7:0]    seg_d;
    logic [5:0]    dig_d;
    logic          blank;

    assign tick = (pcnt == PMAX);
    assign wrap = tick && (idx == 3'd5);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt           <= '0;
            idx            <= '0;
            fcnt           <= '0;
            ph             <= 1'b0;
            snap_hour      <= '0;
            snap_min       <= '0;
            snap_sec       <= '0;
            snap_blink_sel <= '0;
            seg            <= 8'h00;
            dig            <= 6'b111111;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            // The frame boundary is the only point where new inputs are accepted.
            if (wrap) begin
                snap_hour      <= hour;
                snap_min       <= min;
                snap_sec       <= sec;
                snap_blink_sel <= blink_sel;
                if (fcnt == FMAX) begin
                    fcnt <= '0;
                    ph   <= ~ph;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            seg <= seg_d;
            dig <= dig_d;
        end
    end

    always_comb begin
        nib   = 4'h0;
        seg_d = 8'h00;
        blank = 1'b0;
        case (idx)
            3'd0:    nib = snap_hour[7:4];
            3'd1:    nib = snap_hour[3:0];
            3'd2:    nib = snap_min[7:4];
            3'd3:    nib = snap_min[3:0];
            3'd4:    nib = snap_sec[7:4];
            default: nib = snap_sec[3:0];
        endcase
        case (nib)
            4'd0:    seg_d = 8'h3F;
            4'd1:    seg_d = 8'h06;
            4'd2:    seg_d = 8'h5B;
            4'd3:    seg_d = 8'h4F;
            4'd4:    seg_d = 8'h66;
            4'd5:    seg_d = 8'h6D;
            4'd6:    seg_d = 8'h7D;
            4'd7:    seg_d = 8'h07;
            4'd8:    seg_d = 8'h7F;
            4'd9:    seg_d = 8'h6F;
            default: seg_d = 8'h40;
        endcase
        if (idx == 3'd1 || idx == 3'd3) begin
            seg_d[7] = 1'b1;
        end
        // Field number is idx/2; blink_sel codes 1..3 select hours/minutes/seconds.
        blank = ph && (snap_blink_sel != 2'd0) && (snap_blink_sel == idx[2:1] + 2'd1);
        if (blank || (LZB && idx == 3'd0 && nib == 4'h0)) begin
            seg_d = 8'h00;
        end
        dig_d = ~(6'd1 << idx);
    end

endmodule
